mips_multicycle_core: RTL and testbench
=======================================

// Module: mips_multicycle_core
// PURPOSE
//  Multicycle MIPS-subset core: one shared memory port, FSM-sequenced datapath, shared ALU.
//  Replaces the single-cycle datapath: adds memory wait-state handshake, correct sign extension, beq/j/addi, halt.
//  Top-level CPU block; instruction/data memory sits outside on the mem_* port.
// PARAMETERS
//  ADDR_W          32  width of PC and mem_addr; PC wraps modulo 2**ADDR_W
//  RESET_PC        0   PC value loaded at reset (ADDR_W bits)
//  HALT_ON_ILLEGAL 1   1: unknown opcode/funct -> HALT; 0: treated as NOP (retires, PC+4)
// PORTS
//  clk        in   1       clock, rising edge
//  rst        in   1       asynchronous, active-high reset
//  mem_req    out  1       memory access request, held until mem_ready
//  mem_we     out  1       1=write (sw), 0=read (fetch/lw); valid with mem_req
//  mem_addr   out  ADDR_W  byte address; stable while mem_req && !mem_ready
//  mem_wdata  out  32      store data (rt value); valid when mem_we
//  mem_rdata  in   32      read data, sampled in the cycle mem_ready=1
//  mem_ready  in   1       access completes this cycle (may be high in the same cycle as mem_req)
//  pc_o       out  ADDR_W  current PC (address of the instruction in flight)
//  retire     out  1       1-cycle pulse in the final state of each instruction
//  halted     out  1       core stopped; held until reset
// BEHAVIOUR
//  Reset (async): state=BOOT, PC=RESET_PC, IR/A/B/ALUOut/MDR=0, all regs=0.
//  Output values during reset: mem_req=0, mem_we=0, retire=0, halted=0.
//  Reset mid-access: mem_req drops at once; the pending access is abandoned.
//  Outputs are decoded from the registered state. BOOT lasts 1 cycle, then FETCH.
//  States and transitions:
//   BOOT->FETCH
//   FETCH: mem_req=1, we=0, addr=PC. On ready: IR<=rdata, PC<=PC+4 -> DECODE.
//   DECODE: A<=R[rs], B<=R[rt], ALUOut<=PC+(sext(imm)<<2). Next state by opcode:
//    R-type->EXEC_R; lw/sw->MEMADR; addi->EXEC_I; beq->BRANCH; j->JUMP; other->ILLEGAL handling.
//   EXEC_R: ALUOut<=A op B; funct add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A -> WB_RD.
//   WB_RD: R[rd]<=ALUOut, retire -> FETCH.
//   EXEC_I: ALUOut<=A+sext(imm) -> WB_RT.
//   WB_RT: R[rt]<=ALUOut, retire -> FETCH.
//   MEMADR: ALUOut<=A+sext(imm). lw->MEMRD, sw->MEMWR.
//   MEMRD: req, we=0, addr=ALUOut. On ready: MDR<=rdata -> MEMWB.
//   MEMWB: R[rt]<=MDR, retire -> FETCH.
//   MEMWR: req, we=1, addr=ALUOut, wdata=B. On ready: retire -> FETCH.
//   BRANCH: if A==B then PC<=ALUOut. retire -> FETCH.
//   JUMP: PC<={PC[ADDR_W-1:28], IR[25:0], 2'b00}. retire -> FETCH.
//   HALT: terminal, halted=1, no requests.
//  Cycle counts with mem_ready=1 in the request cycle: R/addi/sw 4, lw 5, beq/j 3.
//   Each extra low mem_ready cycle adds 1.
//  Illegal handling: HALT_ON_ILLEGAL=1 -> HALT, no retire; HALT_ON_ILLEGAL=0 -> retire -> FETCH.
//  Arithmetic: 32-bit modulo, no overflow trap. slt is signed. sext = {{16{imm[15]}}, imm}.
//   PC arithmetic is truncated to ADDR_W.
//  Register $0 reads 0; writes to $0 are dropped. Regfile has 2 async read ports, 1 sync write port.
//  Unaligned addresses are passed through unchanged; the memory side owns them.
// STRUCTURE
//  Package mips_pkg: opcode/funct localparams, state_t enum, alu_op_t enum, sext16() function.
//  Sub-module mips_regfile (32x32, $0 hardwired). ALU, FSM and datapath registers live in this module.
// TESTING
//  1 R-type: R1=5, R2=7; add R3,R1,R2 -> R3=12, retire at cycle 4 after FETCH entry.
//    Then slt R4,R2,R1 with R2=-1 -> R4=1.
//  2 lw/sw with mem_ready delayed 3 cycles: sw R3,8(R0) -> write 12 @0x8, addr/wdata stable 4 cycles.
//    Then lw R5,8(R0) -> R5=12.
//  3 beq taken, imm=0xFFFF -> PC=branch_addr (self-loop).
//    beq not taken -> PC=branch_addr+4. Both retire in 3 cycles.
//  4 addi R0,R0,1, then add R6,R0,R0 -> R6=0. addi R7,R0,-4 -> R7=0xFFFFFFFC.
//  5 Opcode 0x3F with HALT_ON_ILLEGAL=1 -> halted=1, mem_req stays 0, no retire.
//    With HALT_ON_ILLEGAL=0 -> retire, PC+4.
//  6 rst asserted mid-MEMRD stall -> mem_req=0 at once, PC=RESET_PC.
//    After release: BOOT 1 cycle, then FETCH @RESET_PC.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS-subset core: opcode and funct
// encodings, the FSM state set, ALU operations and immediate sign extension.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    typedef enum logic [3:0] {
        S_BOOT,
        S_FETCH,
        S_DECODE,
        S_EXEC_R,
        S_WB_RD,
        S_EXEC_I,
        S_WB_RT,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_BRANCH,
        S_JUMP,
        S_HALT
    } state_t;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_SLT
    } alu_op_t;

    // Sign-extend a 16-bit instruction immediate to a full data word.
    function automatic logic [31:0] sext16(input logic [15:0] imm);
        return {{16{imm[15]}}, imm};
    endfunction

endpackage

// File: rtl/mips_regfile.sv
// 32 x 32-bit register file: two asynchronous read ports, one synchronous
// write port. Register $0 always reads as zero and ignores writes.
module mips_regfile (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  raddr1_i,
    input  logic [4:0]  raddr2_i,
    output logic [31:0] rdata1_o,
    output logic [31:0] rdata2_o,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] wdata_i
);

    logic [31:0] regs_q [32];

    // Clear every register on reset; afterwards write any register except $0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i && (waddr_i != 5'd0)) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata1_o = (raddr1_i == 5'd0) ? 32'd0 : regs_q[raddr1_i];
    assign rdata2_o = (raddr2_i == 5'd0) ? 32'd0 : regs_q[raddr2_i];

endmodule

// File: rtl/mips_multicycle_core.sv
// Multicycle MIPS-subset CPU. A single FSM sequences a shared ALU and one
// memory port used for both instruction fetch and load/store traffic.
module mips_multicycle_core
    import mips_pkg::*;
#(
    parameter int                ADDR_W          = 32,
    parameter logic [ADDR_W-1:0] RESET_PC        = '0,
    parameter bit                HALT_ON_ILLEGAL = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] pc_o,
    output logic              retire,
    output logic              halted
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [31:0]       ir_q, ir_d;
    logic [31:0]       a_q, a_d;
    logic [31:0]       b_q, b_d;
    logic [31:0]       aluOut_q, aluOut_d;
    logic [31:0]       mdr_q, mdr_d;

    logic [5:0]        opcode, funct;
    logic [4:0]        rs, rt, rd;
    logic [31:0]       immExt;

    logic [31:0]       rfRdata1, rfRdata2, rfWdata;
    logic [4:0]        rfWaddr;
    logic              rfWe;

    logic [31:0]       aluA, aluB, aluY;
    alu_op_t           aluOp, functOp;
    logic              functLegal, instrLegal;

    logic [ADDR_W-1:0] pcPlus4, jumpTarget;

    assign opcode  = ir_q[31:26];
    assign rs      = ir_q[25:21];
    assign rt      = ir_q[20:16];
    assign rd      = ir_q[15:11];
    assign funct   = ir_q[5:0];
    assign immExt  = sext16(ir_q[15:0]);
    assign pcPlus4 = pc_q + ADDR_W'(4);

    mips_regfile u_regfile (
        .clk      (clk),
        .rst      (rst),
        .raddr1_i (rs),
        .raddr2_i (rt),
        .rdata1_o (rfRdata1),
        .rdata2_o (rfRdata2),
        .we_i     (rfWe),
        .waddr_i  (rfWaddr),
        .wdata_i  (rfWdata)
    );

    // Jump keeps the upper PC bits and replaces the low 28 with the word index.
    always_comb begin
        jumpTarget        = pc_q;
        jumpTarget[27:0]  = {ir_q[25:0], 2'b00};
    end

    // Map the R-type funct field onto an ALU operation and flag unknown functs.
    always_comb begin
        functOp    = ALU_ADD;
        functLegal = 1'b1;
        case (funct)
            FN_ADD:  functOp = ALU_ADD;
            FN_SUB:  functOp = ALU_SUB;
            FN_AND:  functOp = ALU_AND;
            FN_OR:   functOp = ALU_OR;
            FN_SLT:  functOp = ALU_SLT;
            default: functLegal = 1'b0;
        endcase
    end

    // An instruction is legal if its opcode is supported (and funct, for R-type).
    always_comb begin
        instrLegal = 1'b0;
        case (opcode)
            OP_RTYPE:                          instrLegal = functLegal;
            OP_J, OP_BEQ, OP_ADDI, OP_LW, OP_SW: instrLegal = 1'b1;
            default:                           instrLegal = 1'b0;
        endcase
    end

    // Select the shared ALU operands: branch target in DECODE, A op B in
    // EXEC_R, and A + immediate for addi and address generation.
    always_comb begin
        aluA  = a_q;
        aluB  = immExt;
        aluOp = ALU_ADD;
        case (state_q)
            S_DECODE: begin
                aluA = 32'(pc_q);
                aluB = {immExt[29:0], 2'b00};
            end
            S_EXEC_R: begin
                aluB  = b_q;
                aluOp = functOp;
            end
            default: ;
        endcase
    end

    // Shared ALU: modulo-2^32 arithmetic, signed set-less-than.
    always_comb begin
        aluY = aluA + aluB;
        case (aluOp)
            ALU_SUB: aluY = aluA - aluB;
            ALU_AND: aluY = aluA & aluB;
            ALU_OR:  aluY = aluA | aluB;
            ALU_SLT: aluY = {31'd0, $signed(aluA) < $signed(aluB)};
            default: aluY = aluA + aluB;
        endcase
    end

    // Next-state and datapath-register update for every FSM state.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        a_d      = a_q;
        b_d      = b_q;
        aluOut_d = aluOut_q;
        mdr_d    = mdr_q;
        rfWe     = 1'b0;
        rfWaddr  = rt;
        rfWdata  = aluOut_q;
        case (state_q)
            S_BOOT: state_d = S_FETCH;
            S_FETCH: begin
                if (mem_ready) begin
                    ir_d    = mem_rdata;
                    pc_d    = pcPlus4;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                a_d      = rfRdata1;
                b_d      = rfRdata2;
                aluOut_d = aluY;
                if (!instrLegal) begin
                    state_d = HALT_ON_ILLEGAL ? S_HALT : S_FETCH;
                end else begin
                    case (opcode)
                        OP_RTYPE:     state_d = S_EXEC_R;
                        OP_LW, OP_SW: state_d = S_MEMADR;
                        OP_ADDI:      state_d = S_EXEC_I;
                        OP_BEQ:       state_d = S_BRANCH;
                        default:      state_d = S_JUMP;
                    endcase
                end
            end
            S_EXEC_R: begin
                aluOut_d = aluY;
                state_d  = S_WB_RD;
            end
            S_WB_RD: begin
                rfWe    = 1'b1;
                rfWaddr = rd;
                state_d = S_FETCH;
            end
            S_EXEC_I: begin
                aluOut_d = aluY;
                state_d  = S_WB_RT;
            end
            S_WB_RT: begin
                rfWe    = 1'b1;
                state_d = S_FETCH;
            end
            S_MEMADR: begin
                aluOut_d = aluY;
                state_d  = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                if (mem_ready) begin
                    mdr_d   = mem_rdata;
                    state_d = S_MEMWB;
                end
            end
            S_MEMWB: begin
                rfWe    = 1'b1;
                rfWdata = mdr_q;
                state_d = S_FETCH;
            end
            S_MEMWR: begin
                if (mem_ready) begin
                    state_d = S_FETCH;
                end
            end
            S_BRANCH: begin
                if (a_q == b_q) begin
                    pc_d = ADDR_W'(aluOut_q);
                end
                state_d = S_FETCH;
            end
            S_JUMP: begin
                pc_d    = jumpTarget;
                state_d = S_FETCH;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_BOOT;
        endcase
    end

    // State and datapath registers; reset returns to BOOT at RESET_PC.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_BOOT;
            pc_q     <= RESET_PC;
            ir_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            aluOut_q <= '0;
            mdr_q    <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            a_q      <= a_d;
            b_q      <= b_d;
            aluOut_q <= aluOut_d;
            mdr_q    <= mdr_d;
        end
    end

    // Memory and status outputs decoded from the registered state; a store
    // retires in the cycle its handshake completes.
    always_comb begin
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        mem_addr = ADDR_W'(aluOut_q);
        retire   = 1'b0;
        halted   = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_req  = 1'b1;
                mem_addr = pc_q;
            end
            S_MEMRD: mem_req = 1'b1;
            S_MEMWR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                retire  = mem_ready;
            end
            S_DECODE: retire = !instrLegal && !HALT_ON_ILLEGAL;
            S_WB_RD, S_WB_RT, S_MEMWB, S_BRANCH, S_JUMP: retire = 1'b1;
            S_HALT: halted = 1'b1;
            default: ;
        endcase
    end

    assign mem_wdata = b_q;
    assign pc_o      = pc_q;

endmodule

// File: tb/tb_mips_multicycle_core.sv
// Directed testbench for mips_multicycle_core: a small program exercises
// R-type, addi, lw/sw with wait states, beq/j, illegal opcodes and reset.
module tb_mips_multicycle_core;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_req, mem_we, mem_ready, retire, halted;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, pc_o;

    logic        rstB = 1'b1;
    logic        memReqB, memWeB, retireB, haltedB;
    logic [31:0] memAddrB, memWdataB, pcB;
    logic        memReadyB;
    logic [31:0] memRdataB;

    int          vecCount  = 0;
    int          missCount = 0;

    logic [31:0] memArr [0:255];
    int          dataDelay = 3;
    int          waitCnt;
    logic        isData;

    typedef struct {
        int          cycles;
        logic [31:0] nextPc;
        int          chkWord;
        logic [31:0] chkVal;
    } step_t;

    step_t       steps [0:23];
    logic [31:0] prog  [0:24];

    always #5 clk = ~clk;

    mips_multicycle_core #(
        .ADDR_W(32), .RESET_PC(32'h100), .HALT_ON_ILLEGAL(1'b1)
    ) dut (
        .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready), .pc_o(pc_o), .retire(retire), .halted(halted)
    );

    mips_multicycle_core #(
        .ADDR_W(32), .RESET_PC(32'h0), .HALT_ON_ILLEGAL(1'b0)
    ) dutNop (
        .clk(clk), .rst(rstB), .mem_req(memReqB), .mem_we(memWeB),
        .mem_addr(memAddrB), .mem_wdata(memWdataB), .mem_rdata(memRdataB),
        .mem_ready(memReadyB), .pc_o(pcB), .retire(retireB), .halted(haltedB)
    );

    // The second core only ever sees opcode 0x3F with zero wait states.
    assign memReadyB = 1'b1;
    assign memRdataB = 32'hFC00_0000;

    // Memory model: program above 0x100 answers at once, data below 0x100
    // answers after dataDelay low-ready cycles.
    assign isData    = (mem_addr < 32'h100);
    assign mem_ready = mem_req && (isData ? (waitCnt >= dataDelay) : 1'b1);
    assign mem_rdata = memArr[mem_addr[9:2]];

    always @(posedge clk or posedge rst) begin
        if (rst) waitCnt <= 0;
        else if (mem_req && !mem_ready) waitCnt <= waitCnt + 1;
        else waitCnt <= 0;
    end

    always @(posedge clk) begin
        if (!rst && mem_req && mem_we && mem_ready) memArr[mem_addr[9:2]] = mem_wdata;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        vecCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic rstVal);
        @(negedge clk);
        rst = rstVal;
    endtask

    // While a request stalls, address, direction and store data must hold.
    logic [31:0] prevAddr, prevWdata;
    logic        prevWe;
    logic        prevStall = 1'b0;
    int          wrRun = 0;
    int          lastWrCycles = 0;

    always @(negedge clk) begin
        if (rst) begin
            prevStall = 1'b0;
            wrRun     = 0;
        end else begin
            if (prevStall && mem_req) begin
                checkOutput("stall_addr", mem_addr, prevAddr);
                checkOutput("stall_we", 32'(mem_we), 32'(prevWe));
                if (mem_we) checkOutput("stall_wdata", mem_wdata, prevWdata);
            end
            if (mem_req && mem_we) begin
                wrRun++;
                if (mem_ready) begin
                    lastWrCycles = wrRun;
                    wrRun        = 0;
                end
            end
            prevStall = mem_req && !mem_ready;
            prevAddr  = mem_addr;
            prevWdata = mem_wdata;
            prevWe    = mem_we;
        end
    end

    function automatic logic [31:0] encR(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] encI(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    // Run one instruction from its first cycle: wait (bounded) for retire,
    // check its cycle count, then check the PC seen in the next FETCH.
    task automatic runInstr(input int k, input int expCycles, input logic [31:0] expNextPc);
        int n    = 0;
        bit seen = 1'b0;
        while (!seen && n < 64) begin
            n++;
            if (retire) seen = 1'b1;
            else @(negedge clk);
        end
        checkOutput($sformatf("i%0d_retire", k), 32'(seen), 32'd1);
        checkOutput($sformatf("i%0d_cycles", k), 32'(n), 32'(expCycles));
        @(negedge clk);
        checkOutput($sformatf("i%0d_pc", k), pc_o, expNextPc);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int retCnt;
        int reqCnt;

        prog[0]  = encI(6'h08, 5'd0, 5'd1, 16'd5);
        prog[1]  = encI(6'h08, 5'd0, 5'd2, 16'd7);
        prog[2]  = encR(5'd1, 5'd2, 5'd3, 6'h20);
        prog[3]  = encI(6'h2B, 5'd0, 5'd3, 16'd8);
        prog[4]  = encI(6'h23, 5'd0, 5'd5, 16'd8);
        prog[5]  = encI(6'h2B, 5'd0, 5'd5, 16'd12);
        prog[6]  = encI(6'h08, 5'd0, 5'd2, 16'hFFFF);
        prog[7]  = encR(5'd2, 5'd1, 5'd4, 6'h2A);
        prog[8]  = encI(6'h2B, 5'd0, 5'd4, 16'd16);
        prog[9]  = encR(5'd1, 5'd2, 5'd8, 6'h22);
        prog[10] = encR(5'd1, 5'd3, 5'd9, 6'h24);
        prog[11] = encR(5'd1, 5'd3, 5'd10, 6'h25);
        prog[12] = encI(6'h2B, 5'd0, 5'd8, 16'd20);
        prog[13] = encI(6'h2B, 5'd0, 5'd9, 16'd24);
        prog[14] = encI(6'h2B, 5'd0, 5'd10, 16'd28);
        prog[15] = encI(6'h08, 5'd0, 5'd0, 16'd1);
        prog[16] = encR(5'd0, 5'd0, 5'd6, 6'h20);
        prog[17] = encI(6'h08, 5'd0, 5'd7, 16'hFFFC);
        prog[18] = encI(6'h2B, 5'd0, 5'd6, 16'd32);
        prog[19] = encI(6'h2B, 5'd0, 5'd7, 16'd36);
        prog[20] = encI(6'h04, 5'd1, 5'd2, 16'd5);
        prog[21] = {6'h02, 26'h58};
        prog[22] = encI(6'h08, 5'd0, 5'd11, 16'h77);
        prog[23] = encI(6'h08, 5'd0, 5'd11, 16'h77);
        prog[24] = encI(6'h04, 5'd1, 5'd1, 16'hFFFF);

        steps[0]  = '{4, 32'h104, -1, 32'h0};
        steps[1]  = '{4, 32'h108, -1, 32'h0};
        steps[2]  = '{4, 32'h10C, -1, 32'h0};
        steps[3]  = '{7, 32'h110,  2, 32'd12};
        steps[4]  = '{8, 32'h114, -1, 32'h0};
        steps[5]  = '{7, 32'h118,  3, 32'd12};
        steps[6]  = '{4, 32'h11C, -1, 32'h0};
        steps[7]  = '{4, 32'h120, -1, 32'h0};
        steps[8]  = '{7, 32'h124,  4, 32'd1};
        steps[9]  = '{4, 32'h128, -1, 32'h0};
        steps[10] = '{4, 32'h12C, -1, 32'h0};
        steps[11] = '{4, 32'h130, -1, 32'h0};
        steps[12] = '{7, 32'h134,  5, 32'd6};
        steps[13] = '{7, 32'h138,  6, 32'd4};
        steps[14] = '{7, 32'h13C,  7, 32'd13};
        steps[15] = '{4, 32'h140, -1, 32'h0};
        steps[16] = '{4, 32'h144, -1, 32'h0};
        steps[17] = '{4, 32'h148, -1, 32'h0};
        steps[18] = '{7, 32'h14C,  8, 32'h0};
        steps[19] = '{7, 32'h150,  9, 32'hFFFF_FFFC};
        steps[20] = '{3, 32'h154, -1, 32'h0};
        steps[21] = '{3, 32'h160, -1, 32'h0};
        steps[22] = '{3, 32'h160, -1, 32'h0};
        steps[23] = '{3, 32'h160, -1, 32'h0};

        for (int i = 0; i < 256; i++) memArr[i] = 32'h0;
        memArr[8] = 32'hDEAD_BEEF;
        for (int i = 0; i < 25; i++) memArr[64 + i] = prog[i];

        // Reset values
        @(negedge clk);
        @(negedge clk);
        checkOutput("rst_req", 32'(mem_req), 32'd0);
        checkOutput("rst_we", 32'(mem_we), 32'd0);
        checkOutput("rst_retire", 32'(retire), 32'd0);
        checkOutput("rst_halted", 32'(halted), 32'd0);
        checkOutput("rst_pc", pc_o, 32'h100);

        // Illegal opcode treated as a two-cycle NOP
        rstB = 1'b0;
        @(negedge clk);
        checkOutput("nop_fetch_req", 32'(memReqB), 32'd1);
        checkOutput("nop_fetch_pc", pcB, 32'h0);
        @(negedge clk);
        checkOutput("nop_retire0", 32'(retireB), 32'd1);
        checkOutput("nop_halted", 32'(haltedB), 32'd0);
        @(negedge clk);
        checkOutput("nop_pc1", pcB, 32'h4);
        checkOutput("nop_noretire", 32'(retireB), 32'd0);
        @(negedge clk);
        checkOutput("nop_retire1", 32'(retireB), 32'd1);
        @(negedge clk);
        checkOutput("nop_pc2", pcB, 32'h8);

        // Boot, then the main program
        rst = 1'b0;
        #1 checkOutput("boot_req", 32'(mem_req), 32'd0);
        @(negedge clk);
        checkOutput("fetch_req", 32'(mem_req), 32'd1);
        checkOutput("fetch_addr", mem_addr, 32'h100);
        checkOutput("fetch_we", 32'(mem_we), 32'd0);
        for (int k = 0; k < 24; k++) begin
            runInstr(k, steps[k].cycles, steps[k].nextPc);
            if (steps[k].chkWord >= 0)
                checkOutput($sformatf("i%0d_mem", k), memArr[steps[k].chkWord], steps[k].chkVal);
            if (k == 3) checkOutput("sw_req_cycles", 32'(lastWrCycles), 32'd4);
        end

        // Illegal opcode halts the core
        rst = 1'b1;
        memArr[64] = 32'hFC00_0000;
        applyStimulus(1'b0);
        @(negedge clk);
        @(negedge clk);
        checkOutput("ill_decode_retire", 32'(retire), 32'd0);
        retCnt = 0;
        reqCnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (retire) retCnt++;
            if (mem_req) reqCnt++;
        end
        checkOutput("ill_halted", 32'(halted), 32'd1);
        checkOutput("ill_retires", 32'(retCnt), 32'd0);
        checkOutput("ill_reqs", 32'(reqCnt), 32'd0);

        // Reset in the middle of a stalled load
        rst = 1'b1;
        memArr[64] = encI(6'h23, 5'd0, 5'd5, 16'd8);
        applyStimulus(1'b0);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        checkOutput("memrd_req", 32'(mem_req), 32'd1);
        checkOutput("memrd_addr", mem_addr, 32'h8);
        checkOutput("memrd_stall", 32'(mem_ready), 32'd0);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("midrst_req", 32'(mem_req), 32'd0);
        checkOutput("midrst_pc", pc_o, 32'h100);
        checkOutput("midrst_retire", 32'(retire), 32'd0);
        applyStimulus(1'b0);
        #1 checkOutput("reboot_req", 32'(mem_req), 32'd0);
        @(negedge clk);
        checkOutput("refetch_req", 32'(mem_req), 32'd1);
        checkOutput("refetch_addr", mem_addr, 32'h100);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
